req_sel_queue_mc: RTL and testbench

- Parametrised, age-ordered request queue with per-channel selection.
- Upstream pushes {channel, req id} entries. The arbiter names a channel each cycle, and the queue returns the oldest entry for that channel whose id is enabled, then compacts.
- Generalises the fixed 16-entry / 4-channel / 4-bit-id queue to arbitrary depth, channel count and id width.
- Adds a ready handshake, a one-hot LRU-channel hint, per-channel occupancy counters, a sticky parity error with clear, and parity fault injection.

---
 rtl/req_sel_queue_mc_if.sv | 43 ++++
 rtl/req_sel_queue_mc.sv | 121 ++++++++++++
 tb/tb_req_sel_queue_mc.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/req_sel_queue_mc_if.sv
// Push / arbitrate / status bundle for the age-ordered per-channel request queue.
// The master modport is the upstream + arbiter side; the slave modport is the queue.
interface req_sel_queue_mc_if #(
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 4,
    parameter int ID_W   = 4
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic                    p_req_val;
    logic                    p_req_rdy;
    logic [CH_W-1:0]         p_req_ch;
    logic [ID_W-1:0]         p_req_id;
    logic                    p_inj_pe;
    logic                    p_arb_val;
    logic [CH_W-1:0]         p_arb_ch;
    logic [2**ID_W-1:0]      p_req_id_enb;
    logic                    p_sel_val;
    logic [ID_W-1:0]         p_sel_req_id;
    logic [IDX_W-1:0]        p_sel_idx;
    logic [NUM_CH-1:0]       p_lru_ch;
    logic [CNT_W-1:0]        p_cnt;
    logic [NUM_CH*CNT_W-1:0] p_ch_cnt;
    logic                    p_pe;
    logic                    p_pe_sticky;
    logic                    p_pe_clr;

    modport master (
        output p_req_val, p_req_ch, p_req_id, p_inj_pe, p_arb_val, p_arb_ch,
               p_req_id_enb, p_pe_clr,
        input  p_req_rdy, p_sel_val, p_sel_req_id, p_sel_idx, p_lru_ch, p_cnt,
               p_ch_cnt, p_pe, p_pe_sticky
    );

    modport slave (
        input  p_req_val, p_req_ch, p_req_id, p_inj_pe, p_arb_val, p_arb_ch,
               p_req_id_enb, p_pe_clr,
        output p_req_rdy, p_sel_val, p_sel_req_id, p_sel_idx, p_lru_ch, p_cnt,
               p_ch_cnt, p_pe, p_pe_sticky
    );
endinterface

// File: rtl/req_sel_queue_mc.sv
// Age-ordered request queue: entry 0 is oldest, the arbiter pops the oldest enabled
// entry of a named channel, and the queue compacts above the popped slot.
module req_sel_queue_mc #(
    parameter int DEPTH  = 16,
    parameter int NUM_CH = 4,
    parameter int ID_W   = 4
) (
    input logic               clk,
    input logic               rst,
    req_sel_queue_mc_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic            val;
        logic [CH_W-1:0] ch;
        logic [ID_W-1:0] id;
        logic            par;
    } entry_t;

    entry_t           q     [DEPTH];
    entry_t           q_up  [DEPTH];
    entry_t           q_nxt [DEPTH];
    logic [CNT_W-1:0] cnt, cnt_nxt, wr_idx;
    logic [CNT_W-1:0] ch_cnt     [NUM_CH];
    logic [CNT_W-1:0] ch_cnt_nxt [NUM_CH];
    logic [DEPTH-1:0] elig, hit, bad;
    logic             any_hit, pop, push, pe_sticky;
    logic [IDX_W-1:0] sel_idx;
    logic [ID_W-1:0]  sel_id;
    logic [NUM_CH-1:0] lru;
    entry_t           new_ent;

    for (genvar k = 0; k < DEPTH; k++) begin : g_ent
        assign elig[k] = q[k].val & bus.p_req_id_enb[q[k].id];
        assign hit[k]  = elig[k] & (q[k].ch == bus.p_arb_ch);
        // A good entry XORs to 0 over all its fields including val.
        assign bad[k]  = q[k].val & (^q[k]);
        if (k == DEPTH - 1) begin : g_top
            assign q_up[k] = '0;
        end else begin : g_mid
            assign q_up[k] = q[k+1];
        end
    end

    // Lowest-index hit/eligible wins: scan high to low so the last match sticks.
    always_comb begin
        any_hit = 1'b0;
        sel_idx = '0;
        sel_id  = '0;
        lru     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any_hit = 1'b1;
                sel_idx = IDX_W'(k);
                sel_id  = q[k].id;
            end
            if (elig[k]) lru = NUM_CH'(1) << q[k].ch;
        end
    end

    assign pop  = bus.p_arb_val & any_hit;
    assign push = bus.p_req_val & bus.p_req_rdy;

    assign new_ent.val = 1'b1;
    assign new_ent.ch  = bus.p_req_ch;
    assign new_ent.id  = bus.p_req_id;
    assign new_ent.par = (^{1'b1, bus.p_req_ch, bus.p_req_id}) ^ bus.p_inj_pe;

    // On a concurrent pop the tail slides down one, so the push lands at cnt-1.
    assign wr_idx = pop ? cnt - CNT_W'(1) : cnt;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            q_nxt[k] = q[k];
            if (pop && (IDX_W'(k) >= sel_idx)) q_nxt[k] = q_up[k];
            if (push && (CNT_W'(k) == wr_idx)) q_nxt[k] = new_ent;
        end
        cnt_nxt = cnt;
        if (push && !pop) cnt_nxt = cnt + CNT_W'(1);
        else if (pop && !push) cnt_nxt = cnt - CNT_W'(1);
        for (int c = 0; c < NUM_CH; c++) begin
            ch_cnt_nxt[c] = ch_cnt[c];
            if ((push && bus.p_req_ch == CH_W'(c)) && !(pop && bus.p_arb_ch == CH_W'(c)))
                ch_cnt_nxt[c] = ch_cnt[c] + CNT_W'(1);
            else if (!(push && bus.p_req_ch == CH_W'(c)) && (pop && bus.p_arb_ch == CH_W'(c)))
                ch_cnt_nxt[c] = ch_cnt[c] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) q[k] <= '0;
            for (int c = 0; c < NUM_CH; c++) ch_cnt[c] <= '0;
            cnt       <= '0;
            pe_sticky <= 1'b0;
        end else begin
            q      <= q_nxt;
            ch_cnt <= ch_cnt_nxt;
            cnt    <= cnt_nxt;
            // Set wins over clear so an error present this cycle is never lost.
            if (|bad) pe_sticky <= 1'b1;
            else if (bus.p_pe_clr) pe_sticky <= 1'b0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cc
        assign bus.p_ch_cnt[c*CNT_W +: CNT_W] = ch_cnt[c];
    end

    assign bus.p_req_rdy    = (cnt < CNT_W'(DEPTH)) | pop;
    assign bus.p_sel_val    = pop;
    assign bus.p_sel_req_id = sel_id;
    assign bus.p_sel_idx    = sel_idx;
    assign bus.p_lru_ch     = lru;
    assign bus.p_cnt        = cnt;
    assign bus.p_pe         = |bad;
    assign bus.p_pe_sticky  = pe_sticky;
endmodule

// File: tb/tb_req_sel_queue_mc.sv
// Directed bench for req_sel_queue_mc at DEPTH=16, NUM_CH=4, ID_W=4.
module tb_req_sel_queue_mc;
    localparam int DEPTH = 16, NUM_CH = 4, ID_W = 4, CNT_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    req_sel_queue_mc_if #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .ID_W(ID_W)) bus();

    req_sel_queue_mc #(.DEPTH(DEPTH), .NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] chc(input int c);
        return bus.p_ch_cnt[c*CNT_W +: CNT_W];
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.p_req_val    = 1'b0;
        bus.p_req_ch     = '0;
        bus.p_req_id     = '0;
        bus.p_inj_pe     = 1'b0;
        bus.p_arb_val    = 1'b0;
        bus.p_arb_ch     = '0;
        bus.p_req_id_enb = 16'hFFFF;
        bus.p_pe_clr     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.p_req_val = 1'b1;
            bus.p_req_ch  = 2'(i % 4);
            bus.p_req_id  = 4'(i);
            #1;
            chk("push_rdy", bus.p_req_rdy, 1);
            cyc();
        end
        bus.p_req_val = 1'b0;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_cnt", bus.p_cnt, 0);
        chk("rst_chcnt", bus.p_ch_cnt, 0);
        chk("rst_rdy", bus.p_req_rdy, 1);
        chk("rst_selval", bus.p_sel_val, 0);
        chk("rst_selid", bus.p_sel_req_id, 0);
        chk("rst_selidx", bus.p_sel_idx, 0);
        chk("rst_lru", bus.p_lru_ch, 0);
        chk("rst_pe", bus.p_pe, 0);
        chk("rst_sticky", bus.p_pe_sticky, 0);

        // Fill to full; arbiter idle with a stray channel must not pop.
        push_n(16);
        bus.p_arb_ch = 2'd2;
        #1;
        chk("full_rdy", bus.p_req_rdy, 0);
        chk("full_cnt", bus.p_cnt, 16);
        for (int c = 0; c < NUM_CH; c++) chk("full_chcnt", chc(c), 4);
        chk("full_lru", bus.p_lru_ch, 4'b0001);
        chk("idle_selval", bus.p_sel_val, 0);
        cyc();
        chk("idle_cnt", bus.p_cnt, 16);

        // Two pops on ch2.
        bus.p_arb_val = 1'b1;
        bus.p_arb_ch  = 2'd2;
        #1;
        chk("pop1_val", bus.p_sel_val, 1);
        chk("pop1_id", bus.p_sel_req_id, 2);
        chk("pop1_idx", bus.p_sel_idx, 2);
        chk("pop1_rdy", bus.p_req_rdy, 1);
        cyc();
        #1;
        chk("pop2_id", bus.p_sel_req_id, 6);
        chk("pop2_idx", bus.p_sel_idx, 5);
        chk("pop2_cnt_pre", bus.p_cnt, 15);
        cyc();
        bus.p_arb_val = 1'b0;
        #1;
        chk("pop2_cnt", bus.p_cnt, 14);
        chk("pop2_ch2", chc(2), 2);

        // Refill to full with two ch2 entries (ids 2, 6) at indices 14, 15.
        bus.p_req_val = 1'b1;
        bus.p_req_ch  = 2'd2;
        bus.p_req_id  = 4'd2;
        cyc();
        bus.p_req_id  = 4'd6;
        cyc();
        bus.p_req_val = 1'b0;
        #1;
        chk("refill_cnt", bus.p_cnt, 16);
        chk("refill_ch2", chc(2), 4);

        // Full queue: push ch3/id9 alongside a pop on ch0.
        bus.p_req_val = 1'b1;
        bus.p_req_ch  = 2'd3;
        bus.p_req_id  = 4'd9;
        bus.p_arb_val = 1'b1;
        bus.p_arb_ch  = 2'd0;
        #1;
        chk("pp_rdy", bus.p_req_rdy, 1);
        chk("pp_selid", bus.p_sel_req_id, 0);
        chk("pp_selidx", bus.p_sel_idx, 0);
        cyc();
        bus.p_req_val = 1'b0;
        bus.p_arb_val = 1'b0;
        #1;
        chk("pp_cnt", bus.p_cnt, 16);
        chk("pp_ch0", chc(0), 3);
        chk("pp_ch3", chc(3), 5);
        // Only id 9 enabled: old id9 (ch1) is oldest eligible, new ch3 one sits at 15.
        bus.p_req_id_enb = 16'h0200;
        bus.p_arb_val    = 1'b1;
        bus.p_arb_ch     = 2'd3;
        #1;
        chk("new_idx", bus.p_sel_idx, 15);
        chk("new_id", bus.p_sel_req_id, 9);
        chk("new_lru", bus.p_lru_ch, 4'b0010);
        bus.p_req_id_enb = 16'h0000;
        #1;
        chk("noenb_val", bus.p_sel_val, 0);
        chk("noenb_lru", bus.p_lru_ch, 0);
        bus.p_arb_val    = 1'b0;
        bus.p_req_id_enb = 16'hFFFF;

        // Id-mask selection on a fresh queue.
        do_reset();
        push_n(16);
        bus.p_req_id_enb = 16'hFFFE;
        #1;
        chk("mask_lru", bus.p_lru_ch, 4'b0010);
        bus.p_arb_val = 1'b1;
        bus.p_arb_ch  = 2'd0;
        #1;
        chk("mask_id", bus.p_sel_req_id, 4);
        chk("mask_idx", bus.p_sel_idx, 4);
        cyc();
        bus.p_arb_val    = 1'b0;
        bus.p_req_id_enb = 16'hFFFF;
        #1;
        chk("mask_cnt", bus.p_cnt, 15);

        // Parity injection on a push of ch3/id0 into index 15.
        bus.p_req_val = 1'b1;
        bus.p_req_ch  = 2'd3;
        bus.p_req_id  = 4'd0;
        bus.p_inj_pe  = 1'b1;
        #1;
        chk("inj_pe_same", bus.p_pe, 0);
        cyc();
        bus.p_req_val = 1'b0;
        bus.p_inj_pe  = 1'b0;
        bus.p_pe_clr  = 1'b1;
        #1;
        chk("inj_pe", bus.p_pe, 1);
        chk("inj_sticky0", bus.p_pe_sticky, 0);
        cyc();
        bus.p_pe_clr = 1'b0;
        #1;
        chk("inj_sticky_prio", bus.p_pe_sticky, 1);
        bus.p_arb_val    = 1'b1;
        bus.p_arb_ch     = 2'd3;
        bus.p_req_id_enb = 16'h0001;
        #1;
        chk("bad_selval", bus.p_sel_val, 1);
        chk("bad_selidx", bus.p_sel_idx, 15);
        chk("bad_selid", bus.p_sel_req_id, 0);
        cyc();
        bus.p_arb_val    = 1'b0;
        bus.p_req_id_enb = 16'hFFFF;
        #1;
        chk("popped_pe", bus.p_pe, 0);
        chk("popped_sticky", bus.p_pe_sticky, 1);
        chk("popped_cnt", bus.p_cnt, 15);
        bus.p_pe_clr = 1'b1;
        cyc();
        bus.p_pe_clr = 1'b0;
        #1;
        chk("clr_sticky", bus.p_pe_sticky, 0);

        // Reset mid-operation with a push and a pop presented.
        do_reset();
        push_n(8);
        #1;
        chk("pre_rst_cnt", bus.p_cnt, 8);
        rst           = 1'b1;
        bus.p_req_val = 1'b1;
        bus.p_req_ch  = 2'd1;
        bus.p_req_id  = 4'd1;
        bus.p_arb_val = 1'b1;
        bus.p_arb_ch  = 2'd0;
        cyc();
        rst           = 1'b0;
        bus.p_req_val = 1'b0;
        #1;
        chk("mrst_cnt", bus.p_cnt, 0);
        chk("mrst_chcnt", bus.p_ch_cnt, 0);
        chk("mrst_selval", bus.p_sel_val, 0);
        chk("mrst_lru", bus.p_lru_ch, 0);
        chk("mrst_rdy", bus.p_req_rdy, 1);
        bus.p_arb_val = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
